// File: rtl/trapez_peak_sampler.sv
// Trapezoid flat-top peak sampler: threshold trigger, N-sample average, pile-up flags.
// Optional crossing timestamp enabled by TRAPEZ_PEAK_TIMESTAMP_EN.
module trapez_peak_sampler #(
   parameter int DATA_W   = 16,
   parameter int WIDTH_W  = 12,
   parameter int AVG_LOG2 = 2,
   parameter int TIME_W   = 32
) (
   input  logic               clk,
   input  logic               reset,
   input  logic               enable,
   input  logic [DATA_W-1:0]  shaper_data,
   input  logic [DATA_W-1:0]  threshold,
   input  logic [WIDTH_W-1:0] flat_delay,
   input  logic [WIDTH_W-1:0] max_width,
   output logic [DATA_W-1:0]  energy,
   output logic [1:0]         status,
   output logic               energy_valid,
   output logic [TIME_W-1:0]  event_time
);

   localparam int SUM_W = DATA_W + AVG_LOG2;
   localparam int WIN_W = AVG_LOG2 + 1;
   localparam logic [WIN_W-1:0] WIN_LAST =
      WIN_W'((1 << AVG_LOG2) - 1);
   localparam bit ONE_SAMPLE = (AVG_LOG2 == 0);

   typedef enum logic [2:0] {
      IDLE,
      RISE,
      FLAT,
      FALL,
      DONE
   } state_t;

   state_t              state_q, state_d;
   logic [DATA_W-1:0]   thr_q, thr_d;
   logic [WIDTH_W-1:0]  fd_q, fd_d;
   logic [WIDTH_W-1:0]  mw_q, mw_d;
   logic [WIDTH_W-1:0]  idx_q, idx_d;
   logic [WIDTH_W-1:0]  width_q, width_d;
   logic [WIN_W-1:0]    win_q, win_d;
   logic signed [SUM_W-1:0] acc_q, acc_d;
   logic [DATA_W-1:0]   energy_q, energy_d;
   logic [1:0]          status_q, status_d;
   logic                valid_q, valid_d;

   logic [DATA_W-1:0]   thr_use;
   logic                above;
   logic signed [SUM_W-1:0] samp_x;
   logic signed [SUM_W-1:0] acc_sum;
   logic [WIDTH_W-1:0]  width_inc;
   logic                fin;
   logic                fin_short;

`ifdef TRAPEZ_PEAK_TIMESTAMP_EN
   logic [TIME_W-1:0]   ts_q, ts_d;
   logic [TIME_W-1:0]   evl_q, evl_d;
   logic [TIME_W-1:0]   evt_q, evt_d;
`endif

   // Trigger compare uses live threshold only while waiting for a crossing.
   always_comb begin
      thr_use   = (state_q == IDLE) ? threshold : thr_q;
      above     = $signed(shaper_data) > $signed(thr_use);
      samp_x    = SUM_W'($signed(shaper_data));
      acc_sum   = acc_q + samp_x;
      width_inc = (width_q == '1) ? width_q : width_q + 1'b1;
   end

   // Pulse FSM next-state, accumulation and result capture.
   always_comb begin
      state_d   = state_q;
      thr_d     = thr_q;
      fd_d      = fd_q;
      mw_d      = mw_q;
      idx_d     = idx_q;
      width_d   = width_q;
      win_d     = win_q;
      acc_d     = acc_q;
      energy_d  = energy_q;
      status_d  = status_q;
      valid_d   = 1'b0;
      fin       = 1'b0;
      fin_short = 1'b0;
`ifdef TRAPEZ_PEAK_TIMESTAMP_EN
      ts_d      = ts_q + 1'b1;
      evl_d     = evl_q;
      evt_d     = evt_q;
`endif
      if (!enable) begin
         state_d = IDLE;
         acc_d   = '0;
         win_d   = '0;
         idx_d   = '0;
         width_d = '0;
      end else begin
         unique case (state_q)
            IDLE: begin
               if (above) begin
                  thr_d   = threshold;
                  fd_d    = flat_delay;
                  mw_d    = max_width;
                  width_d = WIDTH_W'(1);
`ifdef TRAPEZ_PEAK_TIMESTAMP_EN
                  evl_d   = ts_q;
`endif
                  if (flat_delay == '0) begin
                     acc_d   = samp_x;
                     win_d   = WIN_W'(1);
                     state_d = ONE_SAMPLE ? FALL : FLAT;
                  end else begin
                     acc_d   = '0;
                     win_d   = '0;
                     idx_d   = WIDTH_W'(1);
                     state_d = RISE;
                  end
               end
            end
            RISE: begin
               if (!above) begin
                  fin       = 1'b1;
                  fin_short = 1'b1;
               end else begin
                  width_d = width_inc;
                  if (idx_q == fd_q) begin
                     acc_d   = samp_x;
                     win_d   = WIN_W'(1);
                     state_d = ONE_SAMPLE ? FALL : FLAT;
                  end else begin
                     idx_d = idx_q + 1'b1;
                  end
               end
            end
            FLAT: begin
               if (!above) begin
                  fin       = 1'b1;
                  fin_short = 1'b1;
               end else begin
                  width_d = width_inc;
                  acc_d   = acc_sum;
                  win_d   = win_q + 1'b1;
                  if (win_q == WIN_LAST) begin
                     state_d = FALL;
                  end
               end
            end
            FALL: begin
               if (!above) begin
                  fin = 1'b1;
               end else begin
                  width_d = width_inc;
               end
            end
            DONE: begin
               state_d = IDLE;
               acc_d   = '0;
               win_d   = '0;
               idx_d   = '0;
               width_d = '0;
            end
            default: begin
               state_d = IDLE;
            end
         endcase
         if (fin) begin
            state_d  = DONE;
            valid_d  = 1'b1;
            status_d = {(width_q > mw_q), fin_short};
            energy_d = fin_short ? '0 :
                       acc_q[SUM_W-1:AVG_LOG2];
`ifdef TRAPEZ_PEAK_TIMESTAMP_EN
            evt_d    = evl_q;
`endif
         end
      end
   end

   // State and output registers with asynchronous clear.
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         state_q  <= IDLE;
         thr_q    <= '0;
         fd_q     <= '0;
         mw_q     <= '0;
         idx_q    <= '0;
         width_q  <= '0;
         win_q    <= '0;
         acc_q    <= '0;
         energy_q <= '0;
         status_q <= '0;
         valid_q  <= 1'b0;
`ifdef TRAPEZ_PEAK_TIMESTAMP_EN
         ts_q     <= '0;
         evl_q    <= '0;
         evt_q    <= '0;
`endif
      end else begin
         state_q  <= state_d;
         thr_q    <= thr_d;
         fd_q     <= fd_d;
         mw_q     <= mw_d;
         idx_q    <= idx_d;
         width_q  <= width_d;
         win_q    <= win_d;
         acc_q    <= acc_d;
         energy_q <= energy_d;
         status_q <= status_d;
         valid_q  <= valid_d;
`ifdef TRAPEZ_PEAK_TIMESTAMP_EN
         ts_q     <= ts_d;
         evl_q    <= evl_d;
         evt_q    <= evt_d;
`endif
      end
   end

   assign energy       = energy_q;
   assign status       = status_q;
   assign energy_valid = valid_q;
`ifdef TRAPEZ_PEAK_TIMESTAMP_EN
   assign event_time   = evt_q;
`else
   assign event_time   = '0;
`endif

endmodule

// File: tb/tb_trapez_peak_sampler.sv
// Scoreboard bench for trapez_peak_sampler.
// Directed pulses; monitor pops expected results on each strobe.
module tb_trapez_peak_sampler;

   logic        clk = 1'b0;
   logic        reset;
   logic        enable;
   logic [15:0] shaper_data;
   logic [15:0] threshold;
   logic [11:0] flat_delay;
   logic [11:0] max_width;
   logic [15:0] energy;
   logic [1:0]  status;
   logic        energy_valid;
   logic [31:0] event_time;

   trapez_peak_sampler dut (
      .clk          (clk),
      .reset        (reset),
      .enable       (enable),
      .shaper_data  (shaper_data),
      .threshold    (threshold),
      .flat_delay   (flat_delay),
      .max_width    (max_width),
      .energy       (energy),
      .status       (status),
      .energy_valid (energy_valid),
      .event_time   (event_time)
   );

   always #5 clk = ~clk;

   typedef struct {
      int          e;
      logic [1:0]  st;
      longint      cyc;
      longint      t;
   } exp_t;

   exp_t   sb[$];
   int     stim[$];
   int     n_cmp = 0;
   int     n_bad = 0;
   longint cyc = 0;
   longint tb_ts = 0;

   always @(posedge clk) cyc <= cyc + 1;

   always @(posedge clk or negedge reset) begin
      if (!reset) tb_ts <= 0;
      else        tb_ts <= tb_ts + 1;
   end

   task automatic chk(input string nm, input longint act,
                      input longint req);
      n_cmp++;
      if (act !== req) begin
         n_bad++;
         $display("FAIL %s: got %0d expected %0d", nm, act, req);
      end
   endtask

   task automatic idle(input int n);
      for (int i = 0; i < n; i++) begin
         @(posedge clk); #1;
         shaper_data = 16'd0;
      end
   endtask

   // Drive stim[]; the last sample is the falling one.
   task automatic pulse(input int e, input logic [1:0] st,
                        input bit want);
      bit     crossed = 0;
      longint tc = 0;
      exp_t   x;
      foreach (stim[i]) begin
         @(posedge clk); #1;
         shaper_data = 16'(stim[i]);
         if (!crossed && stim[i] > int'($signed(threshold))) begin
            crossed = 1;
            tc = tb_ts;
         end
      end
      if (want) begin
         x.e   = e;
         x.st  = st;
         x.cyc = cyc + 1;
`ifdef TRAPEZ_PEAK_TIMESTAMP_EN
         x.t   = tc;
`else
         x.t   = 0;
`endif
         sb.push_back(x);
      end
   endtask

   exp_t mx;
   always @(negedge clk) begin
      if (reset === 1'b1 && energy_valid === 1'b1) begin
         if (sb.size() == 0) begin
            n_cmp++;
            n_bad++;
            $display("FAIL unexpected_strobe: got energy %0d expected none",
                     $signed(energy));
         end else begin
            mx = sb.pop_front();
            chk("strobe_cycle", cyc, mx.cyc);
            chk("energy", longint'($signed(energy)), longint'(mx.e));
            chk("status", longint'(status), longint'(mx.st));
            chk("event_time", longint'(event_time), mx.t);
         end
      end
   end

   task automatic clean(input logic [1:0] st);
      stim = '{0, 50, 150, 300, 500, 500, 500, 500, 500, 500, 300, 80};
      pulse(500, st, 1);
      idle(3);
   endtask

   initial begin
      #300000;
      $display("FAIL watchdog: got timeout expected finish");
      $fatal(1, "timeout");
   end

   initial begin
      reset       = 1'b0;
      enable      = 1'b1;
      shaper_data = 16'd0;
      threshold   = 16'd100;
      flat_delay  = 12'd3;
      max_width   = 12'd20;
      repeat (3) @(posedge clk);
      #1;
      chk("rst_energy", longint'(energy), 0);
      chk("rst_status", longint'(status), 0);
      chk("rst_valid", longint'(energy_valid), 0);
      chk("rst_event_time", longint'(event_time), 0);
      reset = 1'b1;
      idle(3);

      clean(2'b00);

      stim = '{0, 150, 300, 500, 500, 80};
      pulse(0, 2'b01, 1);
      idle(3);

      max_width = 12'd5;
      clean(2'b10);
      max_width = 12'd20;

      stim = '{0, 150, 300, 500, 501, 502, 503, 505, 300, 80};
      pulse(502, 2'b00, 1);
      idle(3);

      flat_delay = 12'd0;
      stim = '{0, 500, 500, 500, 500, 80};
      pulse(500, 2'b00, 1);
      idle(3);
      flat_delay = 12'd3;

      @(posedge clk); #1;
      shaper_data = -16'sd2000;
      threshold   = -16'sd1000;
      stim = '{-500, -501, -502, -503, -505, -506, -507, -2000};
      pulse(-506, 2'b00, 1);
      @(posedge clk); #1;
      threshold   = 16'd100;
      shaper_data = 16'd0;
      idle(3);

      stim = '{0, 150, 300, 500, 500, 500};
      pulse(0, 2'b00, 0);
      enable = 1'b0;
      stim = '{500, 300, 80, 0};
      pulse(0, 2'b00, 0);
      idle(2);
      enable = 1'b1;
      idle(2);
      clean(2'b00);

      stim = '{0, 150, 300, 500, 500, 500, 500, 500, 500};
      pulse(0, 2'b00, 0);
      @(posedge clk); #2;
      reset = 1'b0;
      #1;
      chk("midrst_energy", longint'(energy), 0);
      chk("midrst_status", longint'(status), 0);
      chk("midrst_valid", longint'(energy_valid), 0);
      chk("midrst_event_time", longint'(event_time), 0);
      shaper_data = 16'd0;
      @(posedge clk);
      #3;
      reset = 1'b1;
      idle(3);
      clean(2'b00);

      idle(5);
      chk("scoreboard_empty", longint'(sb.size()), 0);
      $display("== %0d vectors applied, %0d miscompares ==",
               n_cmp, n_bad);
      $finish;
   end

endmodule
